// File: rtl/trans_packer.sv
// Byte-stream to 128-bit transaction word packer with frame checking, a word
// FIFO and a registered valid/ack output stage with a one-cycle gap after each ack.
module trans_packer #(
  parameter int           FIFO_DEPTH = 8,
  parameter int           TIMEOUT    = 1000,
  parameter logic [7:0]   HDR_TX     = 8'hA5,
  parameter logic [7:0]   HDR_TX_BLK = 8'hB5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  output logic                          byte_ready_o,
  output logic [127:0]                  data_o,
  output logic                          valid_o,
  input  logic                          ack_i,
  output logic [15:0]                   err_cnt_o,
  output logic [15:0]                   frame_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_PUSH} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [IW-1:0]   idle_q, idle_d, idle_inc;
  logic [119:0]    sr_q, sr_d;
  logic            blk_q, blk_d;
  logic            ready_q, ready_d;
  logic [15:0]     err_q, frm_q;
  logic            err_inc, push, pop, acc, hdr_ok, bad_frame, full, tmo_hit;
  logic [127:0]    word;

  logic [127:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   cnt_q;
  logic            valid_q;
  logic [127:0]    data_q;

  assign acc       = byte_valid_i && ready_q;
  assign hdr_ok    = (byte_i == HDR_TX) || (byte_i == HDR_TX_BLK);
  assign idle_inc  = idle_q + 1'b1;
  assign tmo_hit   = (idle_inc == IW'(TIMEOUT));
  // sr_q holds bytes 1..15: sender [119:72], receiver [71:24], amount [23:0]
  assign bad_frame = (sr_q[23:22] != 2'b00) || (sr_q[119:72] == sr_q[71:24]);
  assign full      = (cnt_q == LW'(FIFO_DEPTH));
  assign word      = {sr_q[119:72], sr_q[71:24], sr_q[21:0], blk_q, 9'h000};
  assign pop       = ack_i && valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_HUNT;
      idx_q   <= '0;
      idle_q  <= '0;
      sr_q    <= '0;
      blk_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      sr_q    <= sr_d;
      blk_q   <= blk_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    sr_d    = sr_q;
    blk_d   = blk_q;
    case (state_q)
      S_HUNT: begin
        if (acc && hdr_ok) begin
          blk_d   = (byte_i == HDR_TX_BLK);
          idx_d   = 4'd1;
          idle_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (acc) begin
          sr_d   = {sr_q[111:0], byte_i};
          idx_d  = idx_q + 4'd1;
          idle_d = '0;
          if (idx_q == 4'd15) state_d = S_PUSH;
        end else if (tmo_hit) begin
          state_d = S_HUNT;
        end else begin
          idle_d = idle_inc;
        end
      end
      S_PUSH: begin
        // a full FIFO holds the frame here indefinitely; no timeout applies
        if (bad_frame || !full) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_comb begin
    err_inc = 1'b0;
    push    = 1'b0;
    ready_d = (state_d != S_PUSH);
    case (state_q)
      S_HUNT:    err_inc = acc && !hdr_ok;
      S_COLLECT: err_inc = !acc && tmo_hit;
      S_PUSH: begin
        err_inc = bad_frame;
        push    = !bad_frame && !full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
      frm_q <= '0;
    end else begin
      if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (push) frm_q <= frm_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head stays in the FIFO while presented; the pop edge drops valid and the
  // following edge may present the next head, giving the one-cycle gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (pop) begin
      valid_q <= 1'b0;
    end else if (!valid_q && cnt_q != '0) begin
      valid_q <= 1'b1;
      data_q  <= mem[rd_q];
    end
  end

  assign byte_ready_o = ready_q;
  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign err_cnt_o    = err_q;
  assign frame_cnt_o  = frm_q;
  assign level_o      = cnt_q;
endmodule

// File: tb/tb_trans_packer.sv
// Directed bench for trans_packer: framing, errors, timeout, FIFO backpressure,
// output handshake and mid-operation reset.
module tb_trans_packer;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         byte_ready_o;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;
  logic [15:0]  err_cnt_o;
  logic [15:0]  frame_cnt_o;
  logic [3:0]   level_o;

  int nvec = 0;
  int nerr = 0;

  trans_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .data_o(data_o), .valid_o(valid_o), .ack_i(ack_i),
    .err_cnt_o(err_cnt_o), .frame_cnt_o(frame_cnt_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] exp_word(input logic blk, input logic [47:0] s,
                                            input logic [47:0] r, input logic [23:0] a);
    return {s, r, a[21:0], blk, 9'h000};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 100) begin
      tick(1);
      n++;
    end
    if (!byte_ready_o) chk("byte_ready_timeout", byte_ready_o, 1);
    tick(1);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [47:0] s,
                            input logic [47:0] r, input logic [23:0] a);
    logic [127:0] f;
    f = {h, s, r, a};
    for (int i = 0; i < 16; i++) send_byte(f[127-8*i -: 8]);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid_o && n < 200) begin
      tick(1);
      n++;
    end
    chk("wait_valid", valid_o, 1);
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; byte_i = '0; byte_valid_i = 1'b0; ack_i = 1'b0;
    tick(3);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ready", byte_ready_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_frame", frame_cnt_o, 0);
    chk("rst_level", level_o, 0);
    rst_n = 1'b1;
    tick(2);
    chk("hunt_ready", byte_ready_o, 1);

    // basic frame and exact latency
    send_frame(8'hA5, 48'h1, 48'h2, 24'h000032);
    tick(1);
    chk("lat_n1_valid", valid_o, 0);
    chk("lat_n1_level", level_o, 1);
    tick(1);
    chk("lat_n2_valid", valid_o, 1);
    chk("f1_data", data_o, {48'h1, 48'h2, 22'h32, 1'b0, 9'h0});
    tick(4);
    chk("f1_hold_valid", valid_o, 1);
    chk("f1_hold_data", data_o, {48'h1, 48'h2, 22'h32, 1'b0, 9'h0});
    do_ack();
    chk("f1_gap", valid_o, 0);
    chk("f1_level", level_o, 0);
    chk("f1_frame", frame_cnt_o, 1);
    tick(2);
    chk("f1_stay_low", valid_o, 0);

    // block-start header
    send_frame(8'hB5, 48'h3, 48'h4, 24'h000064);
    wait_valid();
    chk("blk_bit", data_o[9], 1);
    chk("blk_amt", data_o[31:10], 22'h64);
    chk("blk_word", data_o, exp_word(1'b1, 48'h3, 48'h4, 24'h64));
    do_ack();

    // junk in HUNT then a good frame
    send_byte(8'h00);
    send_byte(8'h17);
    chk("junk_err", err_cnt_o, 2);
    send_frame(8'hA5, 48'h5, 48'h6, 24'h000007);
    wait_valid();
    chk("junk_word", data_o, exp_word(1'b0, 48'h5, 48'h6, 24'h7));
    do_ack();
    tick(3);
    chk("junk_one_word", valid_o, 0);
    chk("junk_frame", frame_cnt_o, 3);

    // rejected frames
    send_frame(8'hA5, 48'h11, 48'h22, 24'hC00001);
    tick(2);
    chk("amt_err", err_cnt_o, 3);
    chk("amt_level", level_o, 0);
    send_frame(8'hA5, 48'h33, 48'h33, 24'h000005);
    tick(2);
    chk("same_err", err_cnt_o, 4);
    chk("same_frame", frame_cnt_o, 3);
    chk("same_valid", valid_o, 0);

    // idle timeout inside a frame
    for (int i = 0; i < 8; i++) send_byte((i == 0) ? 8'hA5 : 8'(i));
    tick(TMO - 1);
    chk("tmo_before", err_cnt_o, 4);
    tick(1);
    chk("tmo_err", err_cnt_o, 5);
    chk("tmo_ready", byte_ready_o, 1);
    send_frame(8'hA5, 48'h44, 48'h55, 24'h000009);
    wait_valid();
    chk("tmo_next_word", data_o, exp_word(1'b0, 48'h44, 48'h55, 24'h9));
    do_ack();
    tick(2);
    chk("pre_fill_level", level_o, 0);

    // fill FIFO plus one held in PUSH
    for (int i = 0; i <= DEPTH; i++)
      send_frame(8'hA5, 48'h100 + 48'(i), 48'h200 + 48'(i), 24'(i + 1));
    chk("full_ready_now", byte_ready_o, 0);
    tick(5);
    chk("full_level", level_o, DEPTH);
    chk("full_ready", byte_ready_o, 0);
    chk("full_frame", frame_cnt_o, 12);
    for (int i = 0; i <= DEPTH; i++) begin
      tick(49);
      chk("drain_valid", valid_o, 1);
      chk("drain_word", data_o, exp_word(1'b0, 48'h100 + 48'(i), 48'h200 + 48'(i), 24'(i + 1)));
      do_ack();
      chk("drain_gap", valid_o, 0);
    end
    tick(3);
    chk("drain_empty_valid", valid_o, 0);
    chk("drain_empty_level", level_o, 0);
    chk("drain_frame", frame_cnt_o, 13);

    // reset with a word presented and a partial frame in flight
    send_frame(8'hA5, 48'hAA, 48'hBB, 24'h000001);
    wait_valid();
    for (int i = 0; i < 5; i++) send_byte((i == 0) ? 8'hA5 : 8'(i));
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_ready", byte_ready_o, 0);
    chk("mid_rst_err", err_cnt_o, 0);
    chk("mid_rst_frame", frame_cnt_o, 0);
    chk("mid_rst_level", level_o, 0);
    rst_n = 1'b1;
    tick(1);
    send_frame(8'hA5, 48'hC, 48'hD, 24'h000002);
    wait_valid();
    chk("post_rst_word", data_o, exp_word(1'b0, 48'hC, 48'hD, 24'h2));
    chk("post_rst_err", err_cnt_o, 0);
    chk("post_rst_frame", frame_cnt_o, 1);
    do_ack();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
